// File: rtl/ysyx_22050854_cache_pkg.sv
`default_nettype none
// ============================================================================
// ysyx_22050854_cache_pkg : shared types/constants for the cache read arbiter
// Revision: 1.0
// ============================================================================
package ysyx_22050854_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef logic [2:0] rd_type_t;

  localparam rd_type_t RD_BYTE  = 3'b000;
  localparam rd_type_t RD_HALF  = 3'b001;
  localparam rd_type_t RD_WORD  = 3'b010;
  localparam rd_type_t RD_DWORD = 3'b011;
  localparam rd_type_t RD_LINE  = 3'b100;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int LINE_BEATS = 2;

  function automatic logic [1:0] expected_beats(input rd_type_t t);
    return (t == RD_LINE) ? 2'(LINE_BEATS) : 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050854_rd_req_slot.sv
`default_nettype none
// ============================================================================
// ysyx_22050854_rd_req_slot : one-entry buffer holding a cache read request
// Revision: 1.0
// ============================================================================
module ysyx_22050854_rd_req_slot
  import ysyx_22050854_cache_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  rd_type_t          req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              clr,
  output logic              pend,
  output rd_type_t          slot_type,
  output logic [ADDR_W-1:0] slot_addr,
  output logic              rdy,
  output logic              req_err
);

  logic              pend_q, pend_d;
  rd_type_t          type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign rdy     = rst & ~pend_q;
  assign req_err = req & ~rdy;

  // Load and clear never coincide: clear targets a pending slot, load an empty one.
  always_comb begin
    pend_d = pend_q;
    type_d = type_q;
    addr_d = addr_q;
    if (req && rdy) begin
      pend_d = 1'b1;
      type_d = req_type;
      addr_d = req_addr;
    end else if (clr) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q <= 1'b0;
      type_q <= RD_BYTE;
      addr_q <= '0;
    end else begin
      pend_q <= pend_d;
      type_q <= type_d;
      addr_q <= addr_d;
    end
  end

  assign pend      = pend_q;
  assign slot_type = type_q;
  assign slot_addr = addr_q;

endmodule
`default_nettype wire

// File: rtl/ysyx_22050854_cache_rd_arbiter.sv
`default_nettype none
// ============================================================================
// ysyx_22050854_cache_rd_arbiter : round-robin share of one AXI read channel
// between I-cache (port 0) and D-cache (port 1).  Revision: 1.0
// ============================================================================
module ysyx_22050854_cache_rd_arbiter
  import ysyx_22050854_cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd_req,
  input  logic [2:0]        i_rd_type,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              i_rd_rdy,
  output logic              i_ret_valid,
  output logic              i_ret_last,
  output logic [DATA_W-1:0] i_ret_data,
  input  logic              d_rd_req,
  input  logic [2:0]        d_rd_type,
  input  logic [ADDR_W-1:0] d_rd_addr,
  output logic              d_rd_rdy,
  output logic              d_ret_valid,
  output logic              d_ret_last,
  output logic [DATA_W-1:0] d_ret_data,
  output logic              m_rd_req,
  output logic [2:0]        m_rd_type,
  output logic [ADDR_W-1:0] m_rd_addr,
  input  logic              m_rd_rdy,
  input  logic              m_ret_valid,
  input  logic              m_ret_last,
  input  logic [DATA_W-1:0] m_ret_data,
  output logic              err
);

  logic              pend_i, pend_d_port, req_err_i, req_err_d, clr_i, clr_d;
  rd_type_t          type_i, type_d_port, g_type;
  logic [ADDR_W-1:0] addr_i, addr_d_port, g_addr;

  ysyx_22050854_rd_req_slot #(.ADDR_W(ADDR_W)) u_slot_i (
    .clk(clk), .rst(rst), .req(i_rd_req), .req_type(i_rd_type), .req_addr(i_rd_addr),
    .clr(clr_i), .pend(pend_i), .slot_type(type_i), .slot_addr(addr_i),
    .rdy(i_rd_rdy), .req_err(req_err_i)
  );

  ysyx_22050854_rd_req_slot #(.ADDR_W(ADDR_W)) u_slot_d (
    .clk(clk), .rst(rst), .req(d_rd_req), .req_type(d_rd_type), .req_addr(d_rd_addr),
    .clr(clr_d), .pend(pend_d_port), .slot_type(type_d_port), .slot_addr(addr_d_port),
    .rdy(d_rd_rdy), .req_err(req_err_d)
  );

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d, last_q, last_d, err_q, err_d;
  logic [1:0] beat_q, beat_d, beat_n;

  assign g_type = (grant_q == PORT_D) ? type_d_port : type_i;
  assign g_addr = (grant_q == PORT_D) ? addr_d_port : addr_i;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    err_d   = err_q | req_err_i | req_err_d;
    clr_i   = 1'b0;
    clr_d   = 1'b0;
    beat_n  = (beat_q == 2'd3) ? 2'd3 : beat_q + 2'd1;
    case (state_q)
      ST_IDLE: begin
        if (m_ret_valid) err_d = 1'b1;
        if (pend_i || pend_d_port) begin
          state_d = ST_ISSUE;
          beat_d  = 2'd0;
          if (pend_i && pend_d_port) grant_d = ~last_q;
          else                       grant_d = pend_d_port ? PORT_D : PORT_I;
        end
      end
      ST_ISSUE: begin
        if (m_ret_valid) err_d = 1'b1;
        if (m_rd_rdy) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (m_ret_valid) begin
          beat_d = beat_n;
          if (m_ret_last) begin
            // A short or long burst is flagged but still retires the request.
            if (beat_n != expected_beats(g_type)) err_d = 1'b1;
            clr_i   = (grant_q == PORT_I);
            clr_d   = (grant_q == PORT_D);
            last_d  = grant_q;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= PORT_I;
      last_q  <= PORT_D;
      beat_q  <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  logic issue_act, wait_i, wait_d;
  assign issue_act = rst & (state_q == ST_ISSUE);
  assign wait_i    = rst & (state_q == ST_WAIT) & (grant_q == PORT_I);
  assign wait_d    = rst & (state_q == ST_WAIT) & (grant_q == PORT_D);

  assign m_rd_req  = issue_act;
  assign m_rd_type = issue_act ? g_type : RD_BYTE;
  assign m_rd_addr = issue_act ? g_addr : '0;

  assign i_ret_valid = wait_i & m_ret_valid;
  assign i_ret_last  = wait_i & m_ret_last;
  assign i_ret_data  = wait_i ? m_ret_data : '0;
  assign d_ret_valid = wait_d & m_ret_valid;
  assign d_ret_last  = wait_d & m_ret_last;
  assign d_ret_data  = wait_d ? m_ret_data : '0;

  assign err = err_q;

endmodule
`default_nettype wire

// File: doc/ysyx_22050854_cache_rd_arbiter.md
# ysyx_22050854_cache_rd_arbiter

Shares the single AXI-side read channel between the I-cache (port 0) and the D-cache (port 1). Each cache's miss interface (rd_req/rd_type/rd_addr/rd_rdy/ret_*) connects to one port, and the memory-side port drives the AXI read bridge. Each port has a one-entry request buffer so that single-cycle request pulses are never lost. Arbitration is round-robin, and returned beats are routed to the granted port until ret_last.

## Interface
- ADDR_W, 32, request address width
- DATA_W, 64, return beat width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- i_rd_req  in  1  I-cache read request pulse, legal only while i_rd_rdy=1
- i_rd_type  in  3  request type: 000 byte, 001 half, 010 word, 011 dword, 100 cache line
- i_rd_addr  in  ADDR_W  I-cache request address
- i_rd_rdy  out  1  I-cache port buffer empty
- i_ret_valid  out  1  return beat valid to I-cache
- i_ret_last  out  1  last return beat to I-cache
- i_ret_data  out  DATA_W  return beat data to I-cache
- d_rd_req, d_rd_type, d_rd_addr, d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data: same signals for the D-cache
- m_rd_req  out  1  memory read request
- m_rd_type  out  3  granted request type
- m_rd_addr  out  ADDR_W  granted request address
- m_rd_rdy  in  1  memory accepts request this cycle
- m_ret_valid  in  1  return beat valid
- m_ret_last  in  1  last return beat
- m_ret_data  in  DATA_W  return beat data
- err  out  1  sticky protocol error

## Operation
- **Per-port slot:** holds pend, type and addr.
  - A request with rd_req=1 and rd_rdy=1 loads the slot and sets pend.
  - rd_rdy = rst & ~pend.
  - rd_req while rd_rdy=0 is ignored and sets err.
- **FSM states:** IDLE, ISSUE and WAIT. A grant register records the port being served (0 = I, 1 = D). A last register records the port served most recently.
- **IDLE:**
  - If exactly one pend is set, grant that port and go to ISSUE.
  - If both are set, grant ~last and go to ISSUE.
  - If neither is set, stay in IDLE.
- **ISSUE:**
  - m_rd_req=1, with m_rd_type and m_rd_addr taken from the granted slot.
  - Go to WAIT on the cycle where m_rd_rdy=1.
  - The request is held stable until accepted.
- **WAIT:**
  - Combinationally route m_ret_valid, m_ret_last and m_ret_data to the granted port.
  - The other port sees ret_valid=0, ret_last=0 and ret_data=0.
  - On m_ret_valid & m_ret_last: clear pend[grant], set last<=grant and go to IDLE.
- **Beat counter:** counts return beats in WAIT and is cleared on entry to ISSUE.
  - Type 100 expects 2 beats; all other types expect 1.
  - If ret_last arrives on the wrong beat count, set err; the transaction still completes.
- **Stray beats:** m_ret_valid in IDLE or ISSUE is dropped and sets err.
- **err:** cleared only by reset.

## Timing
- **Reset (rst=0 at an edge):**
  - state=IDLE, pend=0, last=1 (so the I-cache wins the first tie), err=0, beat counter=0.
  - While rst=0, i_rd_rdy=d_rd_rdy=0, m_rd_req=0, m_rd_type=000, m_rd_addr=0, and all ret outputs are 0.
- **Request latency:** a request pulse at edge T sets pend at T+1. The FSM enters ISSUE at T+2, so m_rd_req is high from T+2 onward (2-cycle latency).
- **Return path:** combinational, 0 cycles.
- **Completion:** ret_last at edge T leaves rd_rdy of the served port at 1 from T+1. The next grant is in ISSUE at T+2.
- **Simultaneous events:**
  - A request on the idle port during WAIT is buffered.
  - A request on one port in the same cycle the other port's ret_last completes is buffered. It wins arbitration if the other port is not pending.
- **Reset mid-transaction:** the transaction is abandoned. Beats that arrive afterwards are dropped and set err; the bench masks err after a mid-operation reset.

## Structure
- The shared package ysyx_22050854_cache_pkg holds:
  - FSM state encoding.
  - RD_BYTE/RD_HALF/RD_WORD/RD_DWORD/RD_LINE constants.
  - PORT_I=0 and PORT_D=1.
  - LINE_BEATS=2.
- Sub-module ysyx_22050854_rd_req_slot: one-entry request buffer (pend/type/addr, load, clear, rdy), instantiated twice.

## Test plan
- **Single I-cache miss:** i_rd_req pulse, type 100, addr 0x80000010, m_rd_rdy=1, beats 0x1111 and 0x2222 (last).
  - Expect m_rd_req 2 cycles later with addr 0x80000010.
  - The I port receives both beats; d_ret_valid stays 0.
  - i_rd_rdy=1 the cycle after last.
- **Simultaneous requests from reset:** I and D both request in the same cycle.
  - The I port is granted first; the D request issues 2 cycles after I's ret_last.
  - Repeat the tie: D is granted next, so the grant alternates.
- **Backpressure:** hold m_rd_rdy=0 for 5 cycles.
  - m_rd_req, m_rd_type and m_rd_addr stay stable for all 5 cycles.
  - The transaction completes after m_rd_rdy rises.
- **D request during I WAIT:** a d_rd_req pulse arrives mid-beat.
  - The D request is buffered, d_rd_rdy=0 the next cycle, and no D beats reach the I port.
- **Protocol errors:**
  - Drive m_ret_valid in IDLE: err=1.
  - Drive ret_last on the first beat of a type-100 transaction: err=1 and the port is released.
  - Reset: err=0.
